// File: rtl/alu_rr_sequencer_pkg.sv
// Shared opcode constants, sequencer state encoding and opcode classification
// for the round-robin ALU sequencer.
package alu_seq_pkg;

  localparam logic [3:0] OP_NEG = 4'b0010;
  localparam logic [3:0] OP_NOT = 4'b0111;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_OP  = 3'd1,
    ST_LOAD_A   = 3'd2,
    ST_LOAD_B   = 3'd3,
    ST_EXEC_OUT = 3'd4,
    ST_RESP     = 3'd5
  } seq_state_t;

  function automatic logic is_single_operand(input logic [3:0] opcode);
    return (opcode == OP_NEG) || (opcode == OP_NOT);
  endfunction

endpackage

// File: rtl/alu_rr_sequencer_if.sv
// Request, datapath-control and response signals of the ALU sequencer.
// master = requesters plus datapath, slave = the sequencer itself.
interface alu_rr_sequencer_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned ID_W    = 2
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [4*NUM_REQ-1:0]     req_opcode;
  logic [WIDTH*NUM_REQ-1:0] req_a;
  logic [WIDTH*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]       req_accept;
  logic [WIDTH-1:0]         dp_bus;
  logic                     load_op;
  logic                     load_a;
  logic                     load_b;
  logic                     load_out;
  logic [WIDTH-1:0]         dp_result;
  logic                     resp_valid;
  logic [ID_W-1:0]          resp_id;
  logic [WIDTH-1:0]         resp_data;
  logic                     resp_ready;
  logic                     busy;

  modport master (
    output req_valid, req_opcode, req_a, req_b, dp_result, resp_ready,
    input  req_accept, dp_bus, load_op, load_a, load_b, load_out,
           resp_valid, resp_id, resp_data, busy
  );

  modport slave (
    input  req_valid, req_opcode, req_a, req_b, dp_result, resp_ready,
    output req_accept, dp_bus, load_op, load_a, load_b, load_out,
           resp_valid, resp_id, resp_data, busy
  );
endinterface

// File: rtl/alu_rr_sequencer_rr_arbiter.sv
// Combinational round-robin grant: first set req_valid bit searching upward
// from rr_ptr+1 with wrap-around. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    grant,
  output logic               any_valid
);

  int unsigned     idx;
  logic [ID_W-1:0] cand;

  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx  = (32'(rr_ptr) + k) % NUM_REQ;
      cand = ID_W'(idx);
      if (!any_valid && req_valid[cand]) begin
        grant     = cand;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rr_sequencer.sv
// Automatic sequencer sharing one multi-cycle ALU datapath among NUM_REQ
// requesters: round-robin grant, one load stage per cycle, valid/ready response.
module alu_rr_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned ID_W    = 2
) (
  input logic               clock,
  input logic               reset,
  alu_rr_sequencer_if.slave bus
);

  seq_state_t       state, state_nxt;
  logic [ID_W-1:0]  rr_ptr, grant, id_q;
  logic             any_valid, do_grant;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  int unsigned      gidx;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .any_valid (any_valid)
  );

  // Grant is suppressed while reset is held so no accept pulse leaks out.
  assign do_grant = (state == ST_IDLE) && any_valid && !reset;
  assign gidx     = 32'(grant);

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (do_grant) state_nxt = ST_LOAD_OP;
      ST_LOAD_OP:  state_nxt = ST_LOAD_A;
      ST_LOAD_A:   state_nxt = is_single_operand(op_q) ? ST_EXEC_OUT : ST_LOAD_B;
      ST_LOAD_B:   state_nxt = ST_EXEC_OUT;
      ST_EXEC_OUT: state_nxt = ST_RESP;
      ST_RESP:     if (bus.resp_ready) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= ID_W'(NUM_REQ - 1);
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      id_q   <= '0;
    end else if (do_grant) begin
      rr_ptr <= grant;
      id_q   <= grant;
      op_q   <= bus.req_opcode[4*gidx +: 4];
      a_q    <= bus.req_a[WIDTH*gidx +: WIDTH];
      b_q    <= bus.req_b[WIDTH*gidx +: WIDTH];
    end
  end

  always_comb begin
    bus.req_accept = '0;
    bus.dp_bus     = '0;
    bus.load_op    = 1'b0;
    bus.load_a     = 1'b0;
    bus.load_b     = 1'b0;
    bus.load_out   = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_id    = '0;
    bus.resp_data  = '0;
    bus.busy       = (state != ST_IDLE);
    case (state)
      ST_IDLE: if (do_grant) bus.req_accept = NUM_REQ'(1) << grant;
      ST_LOAD_OP: begin
        bus.load_op = 1'b1;
        bus.dp_bus  = WIDTH'(op_q);
      end
      ST_LOAD_A: begin
        bus.load_a = 1'b1;
        bus.dp_bus = a_q;
      end
      ST_LOAD_B: begin
        bus.load_b = 1'b1;
        bus.dp_bus = b_q;
      end
      ST_EXEC_OUT: bus.load_out = 1'b1;
      ST_RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_id    = id_q;
        bus.resp_data  = bus.dp_result;
      end
      default: ;
    endcase
  end

endmodule
